// File: rtl/xpb_pkg.sv
// Shared definitions for the XPB lookup/accumulate block: default geometry,
// the table word type, the controller state encoding and a tree-index helper.
package xpb_pkg;

    localparam int XPB_WORD_W   = 1024;
    localparam int XPB_SEG_BITS = 5;
    localparam int XPB_NUM_SEG  = 4;

    typedef logic [XPB_WORD_W-1:0] xpb_word_t;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        CFG   = 2'd2
    } xpb_state_e;

    // Depth of a node in a heap-ordered binary tree (root = 0): floor(log2(node+1)).
    function automatic int node_depth(input int node);
        return $clog2(node + 2) - 1;
    endfunction

endpackage

// File: rtl/xpb_seg_table.sv
// One runtime-loadable residue table: synchronous write, registered read with
// entry 0 forced to zero. XPB_CHECK_EN adds per-entry written flags and rd_err_o.
module xpb_seg_table
    import xpb_pkg::*;
#(
    parameter int WORD_W   = XPB_WORD_W,
    parameter int SEG_BITS = XPB_SEG_BITS
) (
    input  logic                clk,
`ifdef XPB_CHECK_EN
    input  logic                rst,
`endif
    input  logic                we_i,
    input  logic [SEG_BITS-1:0] wr_idx_i,
    input  logic [WORD_W-1:0]   wr_data_i,
    input  logic                rd_en_i,
    input  logic [SEG_BITS-1:0] rd_idx_i,
    output logic [WORD_W-1:0]   rd_data_o
`ifdef XPB_CHECK_EN
    ,
    output logic                rd_err_o
`endif
);

    localparam int DEPTH = 1 << SEG_BITS;

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rd_q;
    logic              rd_zero_q;
    logic              wr_ok;

    // Entry 0 is the implicit zero residue; writes to it are swallowed.
    assign wr_ok = we_i & (wr_idx_i != '0);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_q      <= mem_q[rd_idx_i];
            rd_zero_q <= (rd_idx_i == '0);
        end
    end

    assign rd_data_o = rd_zero_q ? '0 : rd_q;

`ifdef XPB_CHECK_EN
    logic [DEPTH-1:0] written_q;
    logic             rd_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            written_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            if (wr_ok) begin
                written_q[wr_idx_i] <= 1'b1;
            end
            if (rd_en_i) begin
                rd_err_q <= (rd_idx_i != '0) & ~written_q[rd_idx_i];
            end
        end
    end

    assign rd_err_o = rd_err_q;
`endif

endmodule

// File: rtl/xpb_lut_accum.sv
// Multi-segment XPB reduction table with a registered adder tree and a
// RUN/DRAIN/CFG controller that keeps table writes away from in-flight lookups.
// Optional XPB_CHECK_EN adds out_err, flagging hits on never-written entries.
module xpb_lut_accum
    import xpb_pkg::*;
#(
    parameter int WORD_W   = XPB_WORD_W,
    parameter int SEG_BITS = XPB_SEG_BITS,
    parameter int NUM_SEG  = XPB_NUM_SEG,
    parameter int ACC_W    = WORD_W + $clog2(NUM_SEG)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we_i,
    input  logic [$clog2(NUM_SEG)-1:0]  cfg_seg_i,
    input  logic [SEG_BITS-1:0]         cfg_idx_i,
    input  logic [WORD_W-1:0]           cfg_data_i,
    output logic                        cfg_ready_o,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [NUM_SEG*SEG_BITS-1:0] in_idx_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [ACC_W-1:0]            out_sum_o
`ifdef XPB_CHECK_EN
    ,
    output logic                        out_err_o
`endif
);

    localparam int LVL   = $clog2(NUM_SEG);
    localparam int SEG_W = $clog2(NUM_SEG);
    localparam int NODES = NUM_SEG - 1;

    xpb_state_e   state_q;
    logic [LVL:0] vld_q;
    logic         stall;
    logic         accept;
    logic         cfg_commit;
    logic         pipe_busy;

    assign out_valid_o = vld_q[LVL];
    assign stall       = out_valid_o & ~out_ready_i;
    assign pipe_busy   = |vld_q;
    assign accept      = in_valid_i & in_ready_o;
    assign cfg_commit  = cfg_we_i & cfg_ready_o;

    always_comb begin
        cfg_ready_o = 1'b0;
        in_ready_o  = 1'b0;
        case (state_q)
            RUN: begin
                cfg_ready_o = ~pipe_busy;
                in_ready_o  = ~stall & ~cfg_we_i;
            end
            CFG: begin
                cfg_ready_o = 1'b1;
                in_ready_o  = ~stall & ~cfg_we_i;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            case (state_q)
                RUN:     if (cfg_we_i) state_q <= pipe_busy ? DRAIN : CFG;
                DRAIN:   if (!pipe_busy) state_q <= CFG;
                CFG:     if (!cfg_we_i) state_q <= RUN;
                default: state_q <= RUN;
            endcase
        end
    end

    // vld_q[0] is the lookup stage, vld_q[k] the k-th adder level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else if (!stall) begin
            vld_q <= {vld_q[LVL-1:0], accept};
        end
    end

    logic [WORD_W-1:0] rd_data [NUM_SEG];
    logic [ACC_W-1:0]  leaf    [NUM_SEG];
    logic [ACC_W-1:0]  node_w  [NODES];
`ifdef XPB_CHECK_EN
    logic              leaf_err [NUM_SEG];
    logic              node_err [NODES];
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SEG; gi++) begin : g_seg
            localparam logic [SEG_W-1:0] SEG_ID = SEG_W'(gi);

            xpb_seg_table #(
                .WORD_W   (WORD_W),
                .SEG_BITS (SEG_BITS)
            ) u_table (
                .clk       (clk),
`ifdef XPB_CHECK_EN
                .rst       (rst),
`endif
                .we_i      (cfg_commit && (cfg_seg_i == SEG_ID)),
                .wr_idx_i  (cfg_idx_i),
                .wr_data_i (cfg_data_i),
                .rd_en_i   (~stall),
                .rd_idx_i  (in_idx_i[gi*SEG_BITS +: SEG_BITS]),
                .rd_data_o (rd_data[gi])
`ifdef XPB_CHECK_EN
                ,
                .rd_err_o  (leaf_err[gi])
`endif
            );

            assign leaf[gi] = ACC_W'(rd_data[gi]);
        end

        // Heap-ordered tree: node n sums children 2n+1 and 2n+2; the last
        // NUM_SEG heap slots are the table outputs, node 0 drives out_sum.
        for (gi = 0; gi < NODES; gi++) begin : g_node
            localparam int LEFT  = 2 * gi + 1;
            localparam int RIGHT = 2 * gi + 2;
            localparam int LEVEL = LVL - node_depth(gi);

            logic [ACC_W-1:0] a_w;
            logic [ACC_W-1:0] b_w;
            logic [ACC_W-1:0] sum_q;

            if (LEFT >= NODES) begin : g_from_leaf
                assign a_w = leaf[LEFT - NODES];
                assign b_w = leaf[RIGHT - NODES];
            end else begin : g_from_node
                assign a_w = node_w[LEFT];
                assign b_w = node_w[RIGHT];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sum_q <= '0;
                end else if (!stall && vld_q[LEVEL-1]) begin
                    sum_q <= a_w + b_w;
                end
            end

            assign node_w[gi] = sum_q;

`ifdef XPB_CHECK_EN
            logic a_err;
            logic b_err;
            logic err_q;

            if (LEFT >= NODES) begin : g_err_leaf
                assign a_err = leaf_err[LEFT - NODES];
                assign b_err = leaf_err[RIGHT - NODES];
            end else begin : g_err_node
                assign a_err = node_err[LEFT];
                assign b_err = node_err[RIGHT];
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    err_q <= 1'b0;
                end else if (!stall && vld_q[LEVEL-1]) begin
                    err_q <= a_err | b_err;
                end
            end

            assign node_err[gi] = err_q;
`endif
        end
    endgenerate

    assign out_sum_o = node_w[0];
`ifdef XPB_CHECK_EN
    assign out_err_o = node_err[0];
`endif

endmodule
